alu_arbiter: RTL and testbench

- Shares one combinational ALU (alu + alu_control datapath) between two requesters.
- Port 0 is the pipeline EX stage; port 1 is the debug/self-test unit.
- Each port uses a valid/ready request handshake and has its own one-entry registered response slot with valid/ready.
- Arbitration is fixed priority to port 0, with a starvation guard that forces a grant to port 1 after a bounded wait.

---
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the EX stage (port 0) and the debug unit (port 1).
// Port 0 has fixed priority. A starvation counter forces a grant to port 1 after a bounded wait.
// Each port has a one-entry registered response slot.
module alu_arbiter #(
    parameter int NB_REG       = 32,
    parameter int NB_ALU_CTRLI = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int NB_STARVE    = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_req_valid_0,
    input  logic [NB_REG-1:0]       i_req_a_0,
    input  logic [NB_REG-1:0]       i_req_b_0,
    input  logic [NB_ALU_CTRLI-1:0] i_req_ctrl_0,
    output logic                    o_req_ready_0,
    output logic                    o_rsp_valid_0,
    output logic [NB_REG-1:0]       o_rsp_result_0,
    output logic                    o_rsp_zero_0,
    input  logic                    i_rsp_ready_0,
    input  logic                    i_req_valid_1,
    input  logic [NB_REG-1:0]       i_req_a_1,
    input  logic [NB_REG-1:0]       i_req_b_1,
    input  logic [NB_ALU_CTRLI-1:0] i_req_ctrl_1,
    output logic                    o_req_ready_1,
    output logic                    o_rsp_valid_1,
    output logic [NB_REG-1:0]       o_rsp_result_1,
    output logic                    o_rsp_zero_1,
    input  logic                    i_rsp_ready_1,
    output logic [NB_REG-1:0]       o_alu_a,
    output logic [NB_REG-1:0]       o_alu_b,
    output logic [NB_ALU_CTRLI-1:0] o_alu_ctrl,
    input  logic [NB_REG-1:0]       i_alu_result,
    input  logic                    i_alu_zero,
    output logic [1:0]              o_grant
);
    logic                 rsp_valid_0_q, rsp_valid_0_d, rsp_valid_1_q, rsp_valid_1_d;
    logic [NB_REG-1:0]    rsp_result_0_q, rsp_result_0_d, rsp_result_1_q, rsp_result_1_d;
    logic                 rsp_zero_0_q, rsp_zero_0_d, rsp_zero_1_q, rsp_zero_1_d;
    logic [NB_STARVE-1:0] starve_q, starve_d;
    logic                 elig_0, elig_1, force_1, grant_0, grant_1, at_limit;

    // Arbitration and ALU operand mux; reset forces every grant, and therefore the mux, to zero.
    always_comb begin
        elig_0   = i_req_valid_0 && (!rsp_valid_0_q || i_rsp_ready_0);
        elig_1   = i_req_valid_1 && (!rsp_valid_1_q || i_rsp_ready_1);
        at_limit = starve_q >= NB_STARVE'(STARVE_LIMIT);
        force_1  = at_limit && elig_1;
        grant_0  = i_reset && elig_0 && !force_1;
        grant_1  = i_reset && elig_1 && (force_1 || !elig_0);
        o_alu_a    = grant_0 ? i_req_a_0    : grant_1 ? i_req_a_1    : '0;
        o_alu_b    = grant_0 ? i_req_b_0    : grant_1 ? i_req_b_1    : '0;
        o_alu_ctrl = grant_0 ? i_req_ctrl_0 : grant_1 ? i_req_ctrl_1 : '0;
    end

    // Slot next-state: load on grant, drop valid on drain, otherwise hold. Counter saturates at the limit.
    always_comb begin
        rsp_valid_0_d  = grant_0 || (rsp_valid_0_q && !i_rsp_ready_0);
        rsp_valid_1_d  = grant_1 || (rsp_valid_1_q && !i_rsp_ready_1);
        rsp_result_0_d = grant_0 ? i_alu_result : rsp_result_0_q;
        rsp_result_1_d = grant_1 ? i_alu_result : rsp_result_1_q;
        rsp_zero_0_d   = grant_0 ? i_alu_zero : rsp_zero_0_q;
        rsp_zero_1_d   = grant_1 ? i_alu_zero : rsp_zero_1_q;
        starve_d       = (grant_1 || !i_req_valid_1) ? '0 :
                         at_limit ? starve_q : starve_q + NB_STARVE'(1);
    end

    // Response slots and starvation counter; reset drops any pending response.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rsp_valid_0_q  <= 1'b0;
            rsp_valid_1_q  <= 1'b0;
            rsp_result_0_q <= '0;
            rsp_result_1_q <= '0;
            rsp_zero_0_q   <= 1'b0;
            rsp_zero_1_q   <= 1'b0;
            starve_q       <= '0;
        end else begin
            rsp_valid_0_q  <= rsp_valid_0_d;
            rsp_valid_1_q  <= rsp_valid_1_d;
            rsp_result_0_q <= rsp_result_0_d;
            rsp_result_1_q <= rsp_result_1_d;
            rsp_zero_0_q   <= rsp_zero_0_d;
            rsp_zero_1_q   <= rsp_zero_1_d;
            starve_q       <= starve_d;
        end
    end

    assign o_req_ready_0  = grant_0;
    assign o_req_ready_1  = grant_1;
    assign o_grant        = {grant_1, grant_0};
    assign o_rsp_valid_0  = rsp_valid_0_q;
    assign o_rsp_valid_1  = rsp_valid_1_q;
    assign o_rsp_result_0 = rsp_result_0_q;
    assign o_rsp_result_1 = rsp_result_1_q;
    assign o_rsp_zero_0   = rsp_zero_0_q;
    assign o_rsp_zero_1   = rsp_zero_1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench with a per-port response scoreboard and a stand-in combinational ALU.
module tb_alu_arbiter;
    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid_0, i_req_valid_1, i_rsp_ready_0, i_rsp_ready_1;
    logic [31:0] i_req_a_0, i_req_b_0, i_req_a_1, i_req_b_1;
    logic [3:0]  i_req_ctrl_0, i_req_ctrl_1;
    logic        o_req_ready_0, o_req_ready_1, o_rsp_valid_0, o_rsp_valid_1;
    logic [31:0] o_rsp_result_0, o_rsp_result_1;
    logic        o_rsp_zero_0, o_rsp_zero_1;
    logic [31:0] o_alu_a, o_alu_b, alu_result;
    logic [3:0]  o_alu_ctrl;
    logic        alu_zero;
    logic [1:0]  o_grant;
    logic [32:0] alu_out;
    logic [32:0] q0[$], q1[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [31:0] r;
        r = (c == C_AND) ? (a & b) : (c == C_OR) ? (a | b) : (c == C_ADD) ? (a + b) : (c == C_SUB) ? (a - b) : 32'h0;
        return {r == 32'h0, r};
    endfunction

    assign alu_out    = alu_ref(o_alu_a, o_alu_b, o_alu_ctrl);
    assign alu_result = alu_out[31:0];
    assign alu_zero   = alu_out[32];

    alu_arbiter dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_req_valid_0(i_req_valid_0), .i_req_a_0(i_req_a_0), .i_req_b_0(i_req_b_0), .i_req_ctrl_0(i_req_ctrl_0),
        .o_req_ready_0(o_req_ready_0), .o_rsp_valid_0(o_rsp_valid_0), .o_rsp_result_0(o_rsp_result_0),
        .o_rsp_zero_0(o_rsp_zero_0), .i_rsp_ready_0(i_rsp_ready_0),
        .i_req_valid_1(i_req_valid_1), .i_req_a_1(i_req_a_1), .i_req_b_1(i_req_b_1), .i_req_ctrl_1(i_req_ctrl_1),
        .o_req_ready_1(o_req_ready_1), .o_rsp_valid_1(o_rsp_valid_1), .o_rsp_result_1(o_rsp_result_1),
        .o_rsp_zero_1(o_rsp_zero_1), .i_rsp_ready_1(i_rsp_ready_1),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
        .i_alu_result(alu_result), .i_alu_zero(alu_zero), .o_grant(o_grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 64'(o_grant), 64'(2'b00));
        chk({tag, "_rdy"}, 64'({o_req_ready_1, o_req_ready_0}), 64'(2'b00));
        chk({tag, "_alu"}, {o_alu_a, o_alu_b} | 64'(o_alu_ctrl), 64'h0);
        chk({tag, "_rspv"}, 64'({o_rsp_valid_1, o_rsp_valid_0}), 64'(2'b00));
    endtask

    task automatic scoreboard();
        chk("onehot", 64'(o_grant != 2'b11), 64'h1);
        if (o_rsp_valid_0 && i_rsp_ready_0) begin
            if (q0.size() == 0) chk("sb0_unexpected", 64'h1, 64'h0);
            else chk("sb0_rsp", 64'({o_rsp_zero_0, o_rsp_result_0}), 64'(q0.pop_front()));
        end
        if (o_rsp_valid_1 && i_rsp_ready_1) begin
            if (q1.size() == 0) chk("sb1_unexpected", 64'h1, 64'h0);
            else chk("sb1_rsp", 64'({o_rsp_zero_1, o_rsp_result_1}), 64'(q1.pop_front()));
        end
        if (i_req_valid_0 && o_req_ready_0) q0.push_back(alu_ref(i_req_a_0, i_req_b_0, i_req_ctrl_0));
        if (i_req_valid_1 && o_req_ready_1) q1.push_back(alu_ref(i_req_a_1, i_req_b_1, i_req_ctrl_1));
    endtask

    task automatic finish_cycle();
        scoreboard();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd7; i_req_b_0 = 32'd9; i_req_ctrl_0 = C_ADD;
        i_req_valid_1 = 1'b0; i_req_a_1 = 32'd0; i_req_b_1 = 32'd0; i_req_ctrl_1 = C_ADD;
        i_rsp_ready_0 = 1'b1; i_rsp_ready_1 = 1'b1;
        @(negedge clk);
        chk_idle_outputs("in_reset");
        @(posedge clk); #1;
        i_req_valid_0 = 1'b0;
        rst_n = 1'b1;

        // single ADD on port 0
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd2; i_req_b_0 = 32'd1; i_req_ctrl_0 = C_ADD;
        @(negedge clk);
        chk("add_ready0", 64'(o_req_ready_0), 64'h1);
        chk("add_grant", 64'(o_grant), 64'(2'b01));
        chk("add_alu", {o_alu_a[15:0], o_alu_b[15:0], 28'h0, o_alu_ctrl}, {16'd2, 16'd1, 28'h0, C_ADD});
        finish_cycle();
        i_req_valid_0 = 1'b0;
        @(negedge clk);
        chk("add_rsp", 64'({o_rsp_valid_0, o_rsp_zero_0, o_rsp_result_0}), {31'h0, 1'b1, 1'b0, 32'd3});
        finish_cycle();

        // SUB with zero result on port 1
        i_req_valid_1 = 1'b1; i_req_a_1 = 32'd2; i_req_b_1 = 32'd2; i_req_ctrl_1 = C_SUB;
        @(negedge clk);
        chk("sub_grant", 64'(o_grant), 64'(2'b10));
        finish_cycle();
        i_req_valid_1 = 1'b0;
        @(negedge clk);
        chk("sub_rsp", 64'({o_rsp_valid_1, o_rsp_zero_1, o_rsp_result_1}), {31'h0, 1'b1, 1'b1, 32'd0});
        finish_cycle();

        // backpressure on port 0 for three cycles, then drain and refill together
        i_rsp_ready_0 = 1'b0;
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd5; i_req_b_0 = 32'd7; i_req_ctrl_0 = C_ADD;
        @(negedge clk);
        chk("bp_first_ready", 64'(o_req_ready_0), 64'h1);
        finish_cycle();
        i_req_a_0 = 32'd9; i_req_b_0 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall", 64'({o_req_ready_0, o_rsp_valid_0, o_rsp_result_0}), {30'h0, 1'b0, 1'b1, 32'd12});
            finish_cycle();
        end
        i_rsp_ready_0 = 1'b1;
        @(negedge clk);
        chk("bp_refill", 64'({o_req_ready_0, o_rsp_valid_0, o_rsp_result_0}), {30'h0, 1'b1, 1'b1, 32'd12});
        finish_cycle();
        i_req_valid_0 = 1'b0;
        @(negedge clk);
        chk("bp_next", 64'({o_rsp_valid_0, o_rsp_result_0}), {31'h0, 1'b1, 32'd10});
        finish_cycle();
        @(negedge clk);
        chk("bp_empty", 64'(o_rsp_valid_0), 64'h0);
        finish_cycle();

        // asynchronous reset while a port 0 result is held
        i_rsp_ready_0 = 1'b0;
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd4; i_req_b_0 = 32'd4; i_req_ctrl_0 = C_AND;
        @(negedge clk);
        finish_cycle();
        i_req_valid_0 = 1'b0;
        @(negedge clk);
        chk("rst_held", 64'({o_rsp_valid_0, o_rsp_result_0}), {31'h0, 1'b1, 32'd4});
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({o_rsp_valid_0, o_rsp_result_0}), 64'h0);
        q0.delete();
        finish_cycle();
        rst_n = 1'b1;
        i_rsp_ready_0 = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_rst");
        chk("post_rst_data", {o_rsp_result_0, o_rsp_result_1} | 64'({o_rsp_zero_0, o_rsp_zero_1}), 64'h0);
        finish_cycle();

        // contention: port 0 wins four cycles, port 1 is forced on the fifth
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd100; i_req_b_0 = 32'd1; i_req_ctrl_0 = C_ADD;
        i_req_valid_1 = 1'b1; i_req_a_1 = 32'hF0; i_req_b_1 = 32'h0F; i_req_ctrl_1 = C_OR;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("cont_grant_%0d", c), 64'(o_grant), (c % 5 == 4) ? 64'(2'b10) : 64'(2'b01));
            finish_cycle();
            if (c % 5 == 4) i_req_a_1 = i_req_a_1 + 32'h100;
            else i_req_a_0 = i_req_a_0 + 32'd3;
        end
        i_req_valid_0 = 1'b0; i_req_valid_1 = 1'b0;
        @(negedge clk);
        finish_cycle();

        // idle mux with both slots drained
        @(negedge clk);
        chk_idle_outputs("idle");
        finish_cycle();
        chk("q0_drained", 64'(q0.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
